// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: data width, reset PC, bubble instruction
// and the IF/DE pipeline register payload.
package core_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Payload carried from fetch to decode
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_de_t;

  // Sequential next-PC; wraps modulo 2^32
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

  // Force word alignment of a byte address
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/if_de_reg.sv
// IF/DE pipeline register. Flush turns the slot into a NOP bubble while keeping
// the previous pc/pc4; flush wins over stall, stall holds everything.
module if_de_reg
  import core_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INST = NOP_INST
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   stall,
  input  logic   flush,
  input  if_de_t d,
  output if_de_t q
);

  // Reset to a bubble, then flush > stall > load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q.inst  <= BUBBLE_INST;
      q.pc    <= '0;
      q.pc4   <= 32'h0000_0004;
      q.valid <= 1'b0;
    end else if (flush) begin
      q.inst  <= BUBBLE_INST;
      q.valid <= 1'b0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (redirect / hold / +4),
// performance counters, and the IF/DE register feeding decode.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = core_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_de,
  input  logic        br_taken_ex,
  input  logic [31:0] br_target_ex,
  output logic [31:0] inst_de,
  output logic [31:0] pc_de,
  output logic [31:0] pc4_de,
  output logic        valid_de,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
);

  logic [31:0] pc_if;
  if_de_t      if_d;
  if_de_t      de_q;

  assign imem_addr = pc_if;

  // Word fetched this cycle, tagged with its PC, ready to enter IF/DE
  always_comb begin
    if_d       = '0;
    if_d.inst  = imem_rdata;
    if_d.pc    = pc_if;
    if_d.pc4   = pc_plus4(pc_if);
    if_d.valid = 1'b1;
  end

  // PC register: redirect beats stall, otherwise step to the next word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_if <= word_align(RESET_PC);
    end else if (br_taken_ex) begin
      pc_if <= word_align(br_target_ex);
    end else if (!stall_de) begin
      pc_if <= pc_plus4(pc_if);
    end
  end

  // Perf counters: loads into IF/DE and redirects taken, both wrapping silently
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else if (br_taken_ex) begin
      flush_cnt <= flush_cnt + 32'd1;
    end else if (!stall_de) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  if_de_reg #(
    .BUBBLE_INST(NOP_INST)
  ) u_if_de_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .stall(stall_de),
    .flush(br_taken_ex),
    .d    (if_d),
    .q    (de_q)
  );

  assign inst_de  = de_q.inst;
  assign pc_de    = de_q.pc;
  assign pc4_de   = de_q.pc4;
  assign valid_de = de_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by a randomized
// run, all compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall_de;
  logic        br_taken_ex;
  logic [31:0] br_target_ex;
  logic [31:0] inst_de;
  logic [31:0] pc_de;
  logic [31:0] pc4_de;
  logic        valid_de;
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what decode should see after each edge
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_pc_de;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic [31:0] m_fetch;
  logic [31:0] m_flush;

  always #5 clk = ~clk;

  // ROM contents: word index i holds i+1
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return (addr >> 2) + 32'd1;
  endfunction

  assign imem_rdata = rom_word(imem_addr);

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall_de    (stall_de),
    .br_taken_ex (br_taken_ex),
    .br_target_ex(br_target_ex),
    .inst_de     (inst_de),
    .pc_de       (pc_de),
    .pc4_de      (pc4_de),
    .valid_de    (valid_de),
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply the rules for one clock edge to the reference state
  task automatic model_edge(input logic r_n, input logic st, input logic br, input logic [31:0] tgt);
    if (!r_n) begin
      m_pc = 32'h0; m_inst = NOP; m_pc_de = 32'h0; m_pc4 = 32'h4;
      m_valid = 1'b0; m_fetch = 32'h0; m_flush = 32'h0;
    end else if (br) begin
      m_pc = {tgt[31:2], 2'b00};
      m_inst = NOP;
      m_valid = 1'b0;
      m_flush = m_flush + 32'd1;
    end else if (!st) begin
      m_inst  = rom_word(m_pc);
      m_pc_de = m_pc;
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_fetch = m_fetch + 32'd1;
    end
  endtask

  // Drive inputs mid-cycle, take one edge, update the model, then sample
  task automatic apply_stimulus(input logic r_n, input logic st, input logic br, input logic [31:0] tgt);
    @(negedge clk);
    rst_n        = r_n;
    stall_de     = st;
    br_taken_ex  = br;
    br_target_ex = tgt;
    @(posedge clk);
    model_edge(r_n, st, br, tgt);
    #1;
  endtask

  task automatic check_output(input string tag);
    chk({tag, ".imem_addr"}, imem_addr, m_pc);
    chk({tag, ".align"}, {30'd0, imem_addr[1:0]}, 32'd0);
    chk({tag, ".inst_de"}, inst_de, m_inst);
    chk({tag, ".pc_de"}, pc_de, m_pc_de);
    chk({tag, ".pc4_de"}, pc4_de, m_pc4);
    chk({tag, ".valid_de"}, {31'd0, valid_de}, {31'd0, m_valid});
    chk({tag, ".fetch_cnt"}, fetch_cnt, m_fetch);
    chk({tag, ".flush_cnt"}, flush_cnt, m_flush);
  endtask

  initial begin
    logic st, br, rn;
    logic [31:0] tgt;

    rst_n = 1'b0; stall_de = 1'b0; br_taken_ex = 1'b0; br_target_ex = 32'h0;

    // 1. reset for two cycles
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_output("reset");
    chk("reset.inst_lit", inst_de, 32'h13);
    chk("reset.pc4_lit", pc4_de, 32'h4);

    // 2. free run
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    check_output("run1");
    chk("run1.inst_lit", inst_de, 32'd1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    check_output("run2");
    chk("run2.pc_lit", pc_de, 32'h4);

    // 3. stall two cycles at pc_if=8, then release
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("stall1");
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("stall2");
    chk("stall2.addr_lit", imem_addr, 32'h8);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    check_output("release");
    chk("release.inst_lit", inst_de, 32'd3);
    chk("release.fetch_lit", fetch_cnt, 32'd3);
    chk("release.addr_lit", imem_addr, 32'hC);

    // 4. redirect coinciding with a stall
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h40);
    check_output("redir");
    chk("redir.addr_lit", imem_addr, 32'h40);
    chk("redir.flush_lit", flush_cnt, 32'd1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    check_output("redir_next");
    chk("redir_next.inst_lit", inst_de, 32'd17);
    chk("redir_next.pc_lit", pc_de, 32'h40);

    // Back-to-back redirects, second one with a misaligned target
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h100);
    check_output("b2b1");
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h0000_0083);
    check_output("b2b2");
    chk("b2b2.addr_lit", imem_addr, 32'h80);

    // 5. wrap at the top of the address space
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check_output("wrap_redir");
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    check_output("wrap_adv");
    chk("wrap_adv.pc_lit", pc_de, 32'hFFFF_FFFC);
    chk("wrap_adv.pc4_lit", pc4_de, 32'h0);
    chk("wrap_adv.addr_lit", imem_addr, 32'h0);

    // 6. reset while stall and redirect are both asserted
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h1234_5678);
    check_output("mid_reset");
    chk("mid_reset.flush_lit", flush_cnt, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) == 0);
      rn  = ($urandom_range(0, 59) != 0);
      tgt = $urandom;
      apply_stimulus(rn, st, br, tgt);
      check_output("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
